// File: rtl/execute_pipe.sv
// Execute stage of the pipelined RV core: operand forwarding, ALU, branch/jump
// resolution and an iterative M-extension unit. The outputs form the EX/MEM register.
module execute_pipe #(
  parameter int XLEN  = 32,
  parameter int MD_EN = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_rs1_data,
  input  logic [XLEN-1:0] i_rs2_data,
  input  logic [XLEN-1:0] i_imm,
  input  logic [4:0]      i_rs1,
  input  logic [4:0]      i_rs2,
  input  logic [4:0]      i_rd,
  input  logic [2:0]      i_opsel,
  input  logic [3:0]      i_alu_flags,
  input  logic [4:0]      i_br_ctrl,
  input  logic [1:0]      i_res_sel,
  input  logic            i_md,
  input  logic [4:0]      i_exmem_rd,
  input  logic [4:0]      i_memwb_rd,
  input  logic [XLEN-1:0] i_exmem_data,
  input  logic [XLEN-1:0] i_memwb_data,
  output logic            o_stall,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic [4:0]      o_rd,
  output logic [XLEN-1:0] o_next_pc,
  output logic            o_redirect,
  output logic            o_trap
);

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} md_state_t;

  function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x, input logic n);
    return n ? ('0 - x) : x;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_if_dw(input logic [2*XLEN-1:0] x, input logic n);
    return n ? ('0 - x) : x;
  endfunction

  // ---- stage p0: forwarding, ALU, branch resolution ----
  logic [XLEN-1:0] fwd_rs1, fwd_rs2;

  always_comb begin
    fwd_rs1 = i_rs1_data;
    if (i_rs1 != 5'd0 && i_rs1 == i_exmem_rd)      fwd_rs1 = i_exmem_data;
    else if (i_rs1 != 5'd0 && i_rs1 == i_memwb_rd) fwd_rs1 = i_memwb_data;
    fwd_rs2 = i_rs2_data;
    if (i_rs2 != 5'd0 && i_rs2 == i_exmem_rd)      fwd_rs2 = i_exmem_data;
    else if (i_rs2 != 5'd0 && i_rs2 == i_memwb_rd) fwd_rs2 = i_memwb_data;
  end

  logic imm_alu, alu_sub, alu_uns, alu_arith;
  logic br_branch, br_lteq, br_expn, br_jump, br_rjump;
  assign {imm_alu, alu_sub, alu_uns, alu_arith}           = i_alu_flags;
  assign {br_branch, br_lteq, br_expn, br_jump, br_rjump} = i_br_ctrl;

  logic [XLEN-1:0]        op2;
  logic signed [XLEN-1:0] op1_s, op2_s, sra_res;
  logic [SHW-1:0]         shamt;
  logic                   eq, lt_s, lt_u, lt;
  logic [XLEN-1:0]        alu_res;

  assign op2     = imm_alu ? i_imm : fwd_rs2;
  assign op1_s   = signed'(fwd_rs1);
  assign op2_s   = signed'(op2);
  assign shamt   = op2[SHW-1:0];
  assign sra_res = op1_s >>> shamt;
  assign eq      = (fwd_rs1 == op2);
  assign lt_s    = (op1_s < op2_s);
  assign lt_u    = (fwd_rs1 < op2);
  assign lt      = alu_uns ? lt_u : lt_s;

  always_comb begin
    alu_res = '0;
    case (i_opsel)
      3'b000:  alu_res = alu_sub ? (fwd_rs1 - op2) : (fwd_rs1 + op2);
      3'b001:  alu_res = fwd_rs1 << shamt;
      3'b010:  alu_res = {{(XLEN-1){1'b0}}, lt_s};
      3'b011:  alu_res = {{(XLEN-1){1'b0}}, lt_u};
      3'b100:  alu_res = fwd_rs1 ^ op2;
      3'b101:  alu_res = alu_arith ? sra_res : (fwd_rs1 >> shamt);
      3'b110:  alu_res = fwd_rs1 | op2;
      default: alu_res = fwd_rs1 & op2;
    endcase
  end

  logic            taken, redirect;
  logic [XLEN-1:0] pc4, pc_imm, next_pc, ex_result;

  assign pc4      = i_pc + XLEN'(4);
  assign pc_imm   = i_pc + i_imm;
  assign taken    = br_jump | (br_branch & (br_expn ^ (br_lteq ? lt : eq)));
  assign next_pc  = br_rjump ? {alu_res[XLEN-1:1], 1'b0} : (taken ? pc_imm : pc4);
  assign redirect = i_valid & (taken | br_rjump);

  always_comb begin
    case (i_res_sel)
      2'b00:   ex_result = alu_res;
      2'b01:   ex_result = pc4;
      2'b10:   ex_result = i_imm;
      default: ex_result = pc_imm;
    endcase
  end

  // ---- mul/div sequencer: magnitudes iterate XLEN times, signs restored in FIX ----
  md_state_t       md_state;
  logic [CW-1:0]   md_cnt;
  logic            md_req;
  logic [2:0]      md_op;
  logic [XLEN-1:0] md_hi, md_lo, md_b, md_pc4;
  logic [4:0]      md_rd;
  logic            md_neg, md_rneg, md_bzero;

  assign md_req  = (MD_EN != 0) && i_valid && i_md && !i_flush;
  assign o_stall = (md_state == CALC) || (md_state == IDLE && md_req);

  // MULHU, DIVU, REMU are fully unsigned; MULHSU keeps only rs1 signed
  logic a_sgn, b_sgn, a_neg, b_neg;
  assign a_sgn = (i_opsel != 3'b011) && (i_opsel != 3'b101) && (i_opsel != 3'b111);
  assign b_sgn = a_sgn && (i_opsel != 3'b010);
  assign a_neg = a_sgn & fwd_rs1[XLEN-1];
  assign b_neg = b_sgn & fwd_rs2[XLEN-1];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      md_state <= IDLE;
      md_cnt   <= '0;
    end else if (i_flush) begin
      md_state <= IDLE;
    end else begin
      case (md_state)
        IDLE: if (md_req) begin
          md_state <= CALC;
          md_cnt   <= '0;
        end
        CALC: if (md_cnt == CNT_LAST) md_state <= FIX;
              else                    md_cnt   <= md_cnt + CW'(1);
        default: md_state <= IDLE;
      endcase
    end
  end

  logic [XLEN-1:0] mul_add, nxt_hi, nxt_lo;
  logic [XLEN:0]   mul_sum, div_sh, div_dif;

  always_comb begin
    mul_add = md_lo[0] ? md_b : '0;
    mul_sum = {1'b0, md_hi} + {1'b0, mul_add};
    div_sh  = {md_hi, md_lo[XLEN-1]};
    div_dif = div_sh - {1'b0, md_b};
    if (!md_op[2]) begin
      nxt_hi = mul_sum[XLEN:1];
      nxt_lo = {mul_sum[0], md_lo[XLEN-1:1]};
    end else if (!div_dif[XLEN]) begin
      nxt_hi = div_dif[XLEN-1:0];
      nxt_lo = {md_lo[XLEN-2:0], 1'b1};
    end else begin
      nxt_hi = div_sh[XLEN-1:0];
      nxt_lo = {md_lo[XLEN-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (md_state == IDLE && md_req) begin
      md_op    <= i_opsel;
      md_hi    <= '0;
      md_lo    <= neg_if(fwd_rs1, a_neg);
      md_b     <= neg_if(fwd_rs2, b_neg);
      md_neg   <= a_neg ^ b_neg;
      md_rneg  <= a_neg;
      md_bzero <= (fwd_rs2 == '0);
      md_rd    <= i_rd;
      md_pc4   <= pc4;
    end else if (md_state == CALC) begin
      md_hi <= nxt_hi;
      md_lo <= nxt_lo;
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, md_result;

  always_comb begin
    prod_fix = neg_if_dw({md_hi, md_lo}, md_neg);
    quo_fix  = md_bzero ? '1 : neg_if(md_lo, md_neg);
    rem_fix  = neg_if(md_hi, md_rneg);
    if (!md_op[2]) md_result = (md_op[1:0] == 2'b00) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
    else           md_result = md_op[1] ? rem_fix : quo_fix;
  end

  // ---- stage p1: EX/MEM register ----
  logic            vld_p1, redir_p1, trap_p1;
  logic [4:0]      rd_p1;
  logic [XLEN-1:0] res_p1, npc_p1;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      vld_p1   <= 1'b0;
      rd_p1    <= '0;
      redir_p1 <= 1'b0;
      trap_p1  <= 1'b0;
      res_p1   <= '0;
      npc_p1   <= '0;
    end else if (i_flush || o_stall) begin
      vld_p1   <= 1'b0;
      rd_p1    <= '0;
      redir_p1 <= 1'b0;
      trap_p1  <= 1'b0;
    end else if (md_state == FIX) begin
      vld_p1   <= 1'b1;
      rd_p1    <= md_rd;
      redir_p1 <= 1'b0;
      trap_p1  <= 1'b0;
      res_p1   <= md_result;
      npc_p1   <= md_pc4;
    end else begin
      vld_p1   <= i_valid;
      rd_p1    <= i_valid ? i_rd : 5'd0;
      redir_p1 <= redirect;
      trap_p1  <= redirect && (next_pc[1:0] != 2'b00);
      res_p1   <= ex_result;
      npc_p1   <= next_pc;
    end
  end

  assign o_valid    = vld_p1;
  assign o_rd       = rd_p1;
  assign o_redirect = redir_p1;
  assign o_trap     = trap_p1;
  assign o_result   = res_p1;
  assign o_next_pc  = npc_p1;

endmodule

// File: tb/tb_execute_pipe.sv
// Directed bench for execute_pipe: forwarding, ALU, branches, JALR, flush and mul/div.
module tb_execute_pipe;
  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b0;
  logic            i_valid, i_flush, i_md;
  logic [XLEN-1:0] i_pc, i_rs1_data, i_rs2_data, i_imm, i_exmem_data, i_memwb_data;
  logic [4:0]      i_rs1, i_rs2, i_rd, i_exmem_rd, i_memwb_rd, i_br_ctrl;
  logic [2:0]      i_opsel;
  logic [3:0]      i_alu_flags;
  logic [1:0]      i_res_sel;
  logic            o_stall, o_valid, o_redirect, o_trap;
  logic [XLEN-1:0] o_result, o_next_pc;
  logic [4:0]      o_rd;

  int checks = 0;
  int errors = 0;

  execute_pipe #(.XLEN(XLEN), .MD_EN(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush), .i_pc(i_pc),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_imm(i_imm),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_rd(i_rd), .i_opsel(i_opsel), .i_alu_flags(i_alu_flags),
    .i_br_ctrl(i_br_ctrl), .i_res_sel(i_res_sel), .i_md(i_md),
    .i_exmem_rd(i_exmem_rd), .i_memwb_rd(i_memwb_rd),
    .i_exmem_data(i_exmem_data), .i_memwb_data(i_memwb_data),
    .o_stall(o_stall), .o_valid(o_valid), .o_result(o_result), .o_rd(o_rd),
    .o_next_pc(o_next_pc), .o_redirect(o_redirect), .o_trap(o_trap)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_valid = 0; i_flush = 0; i_md = 0; i_pc = '0; i_rs1_data = '0; i_rs2_data = '0;
    i_imm = '0; i_exmem_data = '0; i_memwb_data = '0; i_rs1 = 0; i_rs2 = 0; i_rd = 0;
    i_exmem_rd = 0; i_memwb_rd = 0; i_br_ctrl = 0; i_opsel = 0; i_alu_flags = 0; i_res_sel = 0;
  endtask

  // Drives one mul/div op and follows it to completion; the caller judges the outcome.
  task automatic run_md(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        output int nstall, output bit bubbles_ok, output bit timed_out);
    clear_inputs();
    i_valid = 1; i_md = 1; i_opsel = op; i_rs1 = 1; i_rs2 = 2; i_rd = 7;
    i_rs1_data = a; i_rs2_data = b; i_pc = 32'h300;
    nstall = 0; bubbles_ok = 1; timed_out = 0;
    #1;
    while (o_stall === 1'b1 && nstall < 100) begin
      nstall++;
      step();
      if (o_valid !== 1'b0) bubbles_ok = 0;
    end
    timed_out = (nstall >= 100);
    step();
    i_valid = 0; i_md = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    i_rst = 0;
    repeat (2) step();
    checks++; if (o_valid !== 0 || o_rd !== 0) begin errors++; $display("FAIL reset_ctrl: valid=%b rd=%0d want 0/0", o_valid, o_rd); end
    checks++; if (o_redirect !== 0 || o_trap !== 0) begin errors++; $display("FAIL reset_redir: redirect=%b trap=%b want 0/0", o_redirect, o_trap); end
    checks++; if (o_result !== 0 || o_next_pc !== 0) begin errors++; $display("FAIL reset_data: result=%h next_pc=%h want 0/0", o_result, o_next_pc); end
    checks++; if (o_stall !== 0) begin errors++; $display("FAIL reset_stall: got %b want 0", o_stall); end
    i_rst = 1;
    step();
  endtask

  task automatic test_forwarding();
    clear_inputs();
    i_valid = 1; i_rs1 = 5; i_rs2 = 5; i_rd = 3; i_pc = 32'h40;
    i_rs1_data = 100; i_rs2_data = 200;
    i_exmem_rd = 5; i_exmem_data = 7; i_memwb_rd = 5; i_memwb_data = 9;
    #1;
    checks++; if (o_stall !== 0) begin errors++; $display("FAIL fwd_stall: got %b want 0", o_stall); end
    step();
    checks++; if (o_result !== 32'd14) begin errors++; $display("FAIL fwd_exmem: got %0d want 14", o_result); end
    checks++; if (o_valid !== 1 || o_rd !== 5'd3) begin errors++; $display("FAIL fwd_ctrl: valid=%b rd=%0d want 1/3", o_valid, o_rd); end
    checks++; if (o_next_pc !== 32'h44 || o_redirect !== 0) begin errors++; $display("FAIL fwd_pc: next_pc=%h redirect=%b want 44/0", o_next_pc, o_redirect); end
    i_exmem_rd = 0;
    step();
    checks++; if (o_result !== 32'd18) begin errors++; $display("FAIL fwd_memwb: got %0d want 18", o_result); end
    i_exmem_rd = 5; i_rs1 = 0; i_rs2 = 0;
    step();
    checks++; if (o_result !== 32'd300) begin errors++; $display("FAIL fwd_x0: got %0d want 300", o_result); end
    i_rs1 = 5; i_rs2 = 6;
    step();
    checks++; if (o_result !== 32'd207) begin errors++; $display("FAIL fwd_split: got %0d want 207", o_result); end
  endtask

  task automatic test_alu();
    logic [2:0]  ops [8] = '{3'b000, 3'b101, 3'b101, 3'b001, 3'b010, 3'b011, 3'b100, 3'b000};
    logic [3:0]  fl  [8] = '{4'b0100, 4'b0001, 4'b0000, 4'b1000, 4'b0000, 4'b0010, 4'b0000, 4'b1000};
    logic [31:0] av  [8] = '{32'd10, 32'hF0000000, 32'hF0000000, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hFFFFFFFF};
    logic [31:0] bv  [8] = '{32'd3, 32'd4, 32'd4, 32'd0, 32'd1, 32'd1, 32'hFF00FF00, 32'd0};
    logic [31:0] iv  [8] = '{32'd0, 32'd0, 32'd0, 32'h23, 32'd0, 32'd0, 32'd0, 32'd1};
    logic [31:0] ex  [8] = '{32'd7, 32'hFF000000, 32'h0F000000, 32'd8, 32'd1, 32'd0, 32'h0FF00FF0, 32'd0};
    clear_inputs();
    for (int k = 0; k < 8; k++) begin
      i_valid = 1; i_rs1 = 1; i_rs2 = 2; i_rd = 4;
      i_opsel = ops[k]; i_alu_flags = fl[k]; i_rs1_data = av[k]; i_rs2_data = bv[k]; i_imm = iv[k];
      step();
      checks++; if (o_result !== ex[k]) begin errors++; $display("FAIL alu_%0d: got %h want %h", k, o_result, ex[k]); end
    end
  endtask

  task automatic test_branch();
    logic [4:0]  br  [6] = '{5'b11000, 5'b11000, 5'b10000, 5'b10100, 5'b11100, 5'b00010};
    logic [3:0]  fl  [6] = '{4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic [31:0] av  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd5, 32'hFFFFFFFF, 32'd0};
    logic [31:0] bv  [6] = '{32'd1, 32'd1, 32'd5, 32'd5, 32'd1, 32'd0};
    logic [31:0] npc [6] = '{32'h120, 32'h104, 32'h120, 32'h104, 32'h104, 32'h120};
    logic        rdr [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    clear_inputs();
    for (int k = 0; k < 6; k++) begin
      i_valid = 1; i_rs1 = 1; i_rs2 = 2; i_rd = 1; i_pc = 32'h100; i_imm = 32'h20; i_res_sel = 2'b01;
      i_br_ctrl = br[k]; i_alu_flags = fl[k]; i_rs1_data = av[k]; i_rs2_data = bv[k];
      step();
      checks++; if (o_next_pc !== npc[k] || o_redirect !== rdr[k]) begin errors++; $display("FAIL branch_%0d: next_pc=%h redirect=%b want %h/%b", k, o_next_pc, o_redirect, npc[k], rdr[k]); end
      checks++; if (o_result !== 32'h104 || o_trap !== 0) begin errors++; $display("FAIL branch_link_%0d: result=%h trap=%b want 104/0", k, o_result, o_trap); end
    end
  endtask

  task automatic test_jalr();
    clear_inputs();
    i_valid = 1; i_rs1 = 1; i_rd = 1; i_rs1_data = 32'h1003; i_imm = 0; i_pc = 32'h200;
    i_alu_flags = 4'b1000; i_br_ctrl = 5'b00011; i_res_sel = 2'b01;
    step();
    checks++; if (o_next_pc !== 32'h1002) begin errors++; $display("FAIL jalr_pc: got %h want 1002", o_next_pc); end
    checks++; if (o_redirect !== 1 || o_trap !== 1) begin errors++; $display("FAIL jalr_trap: redirect=%b trap=%b want 1/1", o_redirect, o_trap); end
    checks++; if (o_result !== 32'h204) begin errors++; $display("FAIL jalr_link: got %h want 204", o_result); end
    i_rs1_data = 32'h2000; i_imm = 32'h10; i_res_sel = 2'b11;
    step();
    checks++; if (o_next_pc !== 32'h2010 || o_trap !== 0 || o_result !== 32'h210) begin errors++; $display("FAIL jalr_aligned: next_pc=%h trap=%b result=%h want 2010/0/210", o_next_pc, o_trap, o_result); end
    i_br_ctrl = 0; i_imm = 32'hABC; i_res_sel = 2'b10;
    step();
    checks++; if (o_result !== 32'hABC || o_redirect !== 0) begin errors++; $display("FAIL lui_imm: result=%h redirect=%b want abc/0", o_result, o_redirect); end
  endtask

  task automatic test_flush();
    clear_inputs();
    i_valid = 1; i_flush = 1; i_rs1 = 1; i_rs2 = 2; i_rd = 9; i_pc = 32'h100; i_imm = 32'h20;
    i_br_ctrl = 5'b11000; i_rs1_data = 32'hFFFFFFFF; i_rs2_data = 1;
    step();
    checks++; if (o_valid !== 0 || o_redirect !== 0 || o_rd !== 0) begin errors++; $display("FAIL flush_bubble: valid=%b redirect=%b rd=%0d want 0/0/0", o_valid, o_redirect, o_rd); end
    i_flush = 0; i_md = 1; i_flush = 1;
    #1;
    checks++; if (o_stall !== 0) begin errors++; $display("FAIL flush_md_stall: got %b want 0", o_stall); end
    step();
    clear_inputs();
  endtask

  task automatic test_mul();
    int ns; bit bok, tmo;
    run_md(3'b001, 32'h80000000, 32'd2, ns, bok, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL mulh_timeout: stall count %0d", ns); end
    checks++; if (ns !== 33) begin errors++; $display("FAIL mulh_stall: got %0d cycles want 33", ns); end
    checks++; if (!bok) begin errors++; $display("FAIL mulh_bubbles: valid seen while stalled, want none"); end
    checks++; if (o_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulh_result: got %h want ffffffff", o_result); end
    checks++; if (o_valid !== 1 || o_rd !== 7 || o_next_pc !== 32'h304 || o_redirect !== 0) begin errors++; $display("FAIL mulh_ctrl: valid=%b rd=%0d next_pc=%h redirect=%b want 1/7/304/0", o_valid, o_rd, o_next_pc, o_redirect); end
    run_md(3'b011, 32'h80000000, 32'd2, ns, bok, tmo);
    checks++; if (o_result !== 32'h1 || ns !== 33) begin errors++; $display("FAIL mulhu: result=%h stall=%0d want 1/33", o_result, ns); end
    run_md(3'b000, 32'hFFFFFFFD, 32'd5, ns, bok, tmo);
    checks++; if (o_result !== 32'hFFFFFFF1) begin errors++; $display("FAIL mul_low: got %h want fffffff1", o_result); end
    run_md(3'b010, 32'hFFFFFFFF, 32'd2, ns, bok, tmo);
    checks++; if (o_result !== 32'hFFFFFFFF) begin errors++; $display("FAIL mulhsu: got %h want ffffffff", o_result); end
  endtask

  task automatic test_div();
    logic [2:0]  ops [8] = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b111};
    logic [31:0] av  [8] = '{32'd100, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bv  [8] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'h10, 32'h10};
    logic [31:0] ex  [8] = '{32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'h0FFFFFFF, 32'hF};
    int ns; bit bok, tmo;
    for (int k = 0; k < 8; k++) begin
      run_md(ops[k], av[k], bv[k], ns, bok, tmo);
      checks++; if (o_result !== ex[k] || ns !== 33 || o_valid !== 1) begin errors++; $display("FAIL div_%0d: result=%h stall=%0d valid=%b want %h/33/1", k, o_result, ns, o_valid, ex[k]); end
    end
  endtask

  task automatic test_abort_flush();
    int ns; bit bok, tmo, seen;
    clear_inputs();
    i_valid = 1; i_md = 1; i_opsel = 3'b101; i_rs1 = 1; i_rs2 = 2; i_rd = 7;
    i_rs1_data = 32'd100; i_rs2_data = 32'd7;
    #1;
    checks++; if (o_stall !== 1) begin errors++; $display("FAIL abort_f_start: stall=%b want 1", o_stall); end
    repeat (10) step();
    i_flush = 1;
    step();
    i_flush = 0; i_valid = 0; i_md = 0;
    #1;
    checks++; if (o_stall !== 0 || o_valid !== 0) begin errors++; $display("FAIL abort_f_stop: stall=%b valid=%b want 0/0", o_stall, o_valid); end
    seen = 0;
    repeat (40) begin step(); if (o_valid !== 0) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL abort_f_ghost: valid=1 seen after flush, want 0"); end
    run_md(3'b101, 32'd100, 32'd7, ns, bok, tmo);
    checks++; if (o_result !== 32'd14 || ns !== 33) begin errors++; $display("FAIL abort_f_next: result=%0d stall=%0d want 14/33", o_result, ns); end
  endtask

  task automatic test_abort_reset();
    int ns; bit bok, tmo, seen;
    clear_inputs();
    i_valid = 1; i_md = 1; i_opsel = 3'b000; i_rs1 = 1; i_rs2 = 2; i_rd = 7;
    i_rs1_data = 32'd3; i_rs2_data = 32'd4;
    repeat (5) step();
    i_rst = 0;
    clear_inputs();
    #1;
    checks++; if (o_stall !== 0 || o_valid !== 0) begin errors++; $display("FAIL abort_r_stop: stall=%b valid=%b want 0/0", o_stall, o_valid); end
    step();
    i_rst = 1;
    seen = 0;
    repeat (40) begin step(); if (o_valid !== 0) seen = 1; end
    checks++; if (seen) begin errors++; $display("FAIL abort_r_ghost: valid=1 seen after reset, want 0"); end
    run_md(3'b000, 32'd6, 32'd7, ns, bok, tmo);
    checks++; if (o_result !== 32'd42 || ns !== 33) begin errors++; $display("FAIL abort_r_next: result=%0d stall=%0d want 42/33", o_result, ns); end
  endtask

  task automatic test_back_to_back();
    int ns; bit bok, tmo;
    clear_inputs();
    i_valid = 1; i_rs1 = 1; i_rs2 = 2; i_rd = 2; i_rs1_data = 1; i_rs2_data = 2;
    step();
    checks++; if (o_result !== 32'd3 || o_valid !== 1) begin errors++; $display("FAIL b2b_pre: result=%0d valid=%b want 3/1", o_result, o_valid); end
    run_md(3'b111, 32'd23, 32'd5, ns, bok, tmo);
    checks++; if (o_result !== 32'd3 || ns !== 33) begin errors++; $display("FAIL b2b_remu: result=%0d stall=%0d want 3/33", o_result, ns); end
    i_valid = 1; i_opsel = 3'b100; i_rd = 8; i_rs1_data = 32'hFF; i_rs2_data = 32'h0F;
    #1;
    checks++; if (o_stall !== 0) begin errors++; $display("FAIL b2b_nostall: got %b want 0", o_stall); end
    step();
    checks++; if (o_result !== 32'hF0 || o_rd !== 8) begin errors++; $display("FAIL b2b_xor: result=%h rd=%0d want f0/8", o_result, o_rd); end
    i_opsel = 3'b110; i_rd = 0;
    step();
    checks++; if (o_result !== 32'hFF || o_rd !== 0 || o_valid !== 1) begin errors++; $display("FAIL b2b_or: result=%h rd=%0d valid=%b want ff/0/1", o_result, o_rd, o_valid); end
    i_valid = 0;
    step();
    checks++; if (o_valid !== 0 || o_rd !== 0) begin errors++; $display("FAIL b2b_idle: valid=%b rd=%0d want 0/0", o_valid, o_rd); end
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_alu();
    test_branch();
    test_jalr();
    test_flush();
    test_mul();
    test_div();
    test_abort_flush();
    test_abort_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/execute_pipe.md
# execute_pipe

Parametrised execute stage for the pipelined RV core: operand forwarding from EX/MEM and MEM/WB, ALU, branch/jump resolution and an iterative M-extension multiply/divide unit that stalls the front end. All outputs are registered, so this block also is the EX/MEM pipeline register. It sits between decode/register-read and the memory stage.

## Interface
- XLEN, 32: datapath width; must be even and ≥8.
- MD_EN, 1: 1 builds the mul/div unit; 0 treats i_md as a plain ALU op.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  instruction present in EX.
- i_flush  in  1  synchronous kill of the EX instruction and any mul/div in flight.
- i_pc  in  XLEN  instruction PC.
- i_rs1_data / i_rs2_data  in  XLEN each  register-file read data.
- i_imm  in  XLEN  sign-extended immediate.
- i_rs1 / i_rs2 / i_rd  in  5 each  source/destination numbers; i_rd=0 means no write.
- i_opsel  in  3  funct3: ALU op, or mul/div op when i_md=1.
- i_alu_flags  in  4  {imm_alu, sub, unsigned, arith}.
- i_br_ctrl  in  5  {branch, check_lt_or_eq, branch_expect_n, jump, reg_jump}.
- i_res_sel  in  2  00 ALU/MD, 01 pc+4, 10 imm, 11 pc+imm.
- i_md  in  1  M-extension instruction.
- i_exmem_rd / i_memwb_rd  in  5 each  destination of older instructions (0 = no write).
- i_exmem_data / i_memwb_data  in  XLEN each  their result values.
- o_stall  out  1  hold upstream stages and inputs this cycle.
- o_valid  out  1  EX/MEM entry valid.
- o_result  out  XLEN  selected result.
- o_rd  out  5  destination; forced 0 when o_valid=0.
- o_next_pc  out  XLEN  resolved next PC.
- o_redirect  out  1  taken branch/jump; fetch must load o_next_pc.
- o_trap  out  1  o_redirect with o_next_pc[1:0]≠0.

## Operation
- Forwarding per source: i_rsN≠0 and =i_exmem_rd → i_exmem_data; else =i_memwb_rd → i_memwb_data; else register data. EX/MEM wins when both match. Operand 2 uses its own rs2 compare.
- ALU op2 = imm_alu ? i_imm : forwarded rs2. ALU ops by funct3 (RV32I): add/sub, sll, slt, sltu, xor, srl/sra, or, and; shift amount = op2[log2(XLEN)-1:0]. eq/lt from forwarded rs1 vs op2, lt signed unless unsigned.
- Taken = jump | (branch & (branch_expect_n ^ (check_lt_or_eq ? lt : eq))). o_next_pc = reg_jump ? {alu[XLEN-1:1],0} : taken ? pc+imm : pc+4. o_redirect = valid & (taken|reg_jump). All adds wrap modulo 2^XLEN.
- Mul/div funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Operands converted to magnitude, radix-2 shift-add / restoring divide over XLEN iterations, sign fix in final state.
- Divide by zero: quotient all-ones, remainder = dividend. Overflow (−2^(XLEN−1) / −1): quotient = dividend, remainder 0. Both still take full latency.
- FSM: IDLE → CALC on i_valid & i_md & !i_flush (operands latched); CALC counts XLEN cycles → FIX; FIX → IDLE while loading the output register. i_flush or reset in any state → IDLE, result discarded, no output.
- o_stall = (state==CALC) | (state==IDLE & i_valid & i_md & !i_flush).

## Timing
- Reset: o_valid, o_result, o_rd, o_next_pc, o_redirect, o_trap all 0; FSM in IDLE.
- Non-MD: inputs at cycle N → outputs valid after edge ending N; zero stall.
- MD accepted in cycle N: o_stall high cycles N..N+XLEN. FIX is cycle N+XLEN+1 (stall low). Result on outputs after that edge. o_valid=0 bubbles while stalled.
- i_flush in cycle N: next output bubble (o_valid=0, o_redirect=0).

## Test plan
- Forwarding: i_rs1=i_rs2=5, exmem_rd=5 (data 7), memwb_rd=5 (data 9), add → o_result=14; same with rs=0 → register data used.
- Branch: BLT signed, rs1=−1, rs2=1, pc=0x100, imm=0x20 → o_next_pc=0x120, o_redirect=1; BLTU same operands → 0x104, o_redirect=0.
- JALR: rs1=0x1003, imm=0 → o_next_pc=0x1002, o_trap=1, o_result=pc+4 with res_sel=01.
- MUL timing (XLEN=32): MULH 0x80000000×2 → o_stall 33 cycles, result 0xFFFFFFFF after cycle 34; MULHU → 0x1.
- Divide corners: DIV x/0 → 0xFFFFFFFF; REM 7/0 → 7; DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Abort: assert i_flush at CALC cycle 10, or pulse i_rst low → o_stall low next cycle, no o_valid, next MD starts clean.
